dnn_core_array: RTL and testbench
=================================

DNN_CORE_ARRAY -- requirements
Module: dnn_core_array

Interface
REQ-001 SHALL have parameter F_NUM, default 16: number of parallel filter cores, 2..64.
REQ-002 SHALL have parameter DW, default 16: signed fixed-point data, weight and bias width.
REQ-003 SHALL have parameter FRAC, default 8: fraction bits of d, wd, bias and out_data.
REQ-004 SHALL have parameter AW, default 10: weight address width; per-core weight depth is 2**AW.
REQ-005 SHALL have parameter ACCW, default 40: signed accumulator width, at least 2*DW+8.
REQ-006 SHALL have the following ports:
- clk  in  1  clock.
- reset  in  1  reset.
- init  in  1  clear accumulators, start a kernel.
- exec  in  1  MAC enable.
- wa  in  AW  weight address for exec/wwrite.
- d  in  DW  activation operand.
- fin  in  1  end of kernel.
- bias_en  in  1  add bias at fin.
- relu  in  1  clamp negative results at fin.
- wwrite  in  1  weight write.
- bwrite  in  1  bias write.
- wsel  in  $clog2(F_NUM)  target core for wwrite/bwrite.
- wd  in  DW  write data.
- out_valid  out  1  result valid.
- out_data  out  DW  result.
- out_last  out  1  last core result.
- out_ready  in  1  sink ready.
- busy  out  1  state != IDLE.
REQ-007 SHALL use one clock, clk; reset is asynchronous and active-high.

Function
REQ-008 SHALL implement FSM IDLE, ACC, DRAIN, OUT; busy=1 in every state except IDLE.
REQ-009 SHALL go IDLE->ACC on init; in ACC, init SHALL clear all accumulators and stay in ACC.
REQ-010 SHALL, in ACC with exec=1, register w[i][wa] and d (stage 1), then add w*d (full 2*DW signed product, sign-extended) into acc[i] on the next cycle (stage 2), for all cores in parallel.
REQ-011 SHALL accept exec back-to-back every cycle; exec SHALL be ignored outside ACC.
REQ-012 SHALL go ACC->DRAIN on fin; an exec in the same cycle as fin SHALL be included in the result.
REQ-013 SHALL stay in DRAIN exactly 2 cycles, then compute every core result in one cycle and enter OUT.
REQ-014 SHALL compute each result as follows:
- r = acc + (bias_en ? bias<<FRAC : 0) + 2**(FRAC-1), arithmetic shift right by FRAC.
- Saturate r to signed DW range.
- If relu, force negative r to 0.
- bias_en and relu SHALL be sampled on the fin cycle.
REQ-015 SHALL, in OUT, present results of cores 0..F_NUM-1 in order; a transfer occurs when out_valid&&out_ready.
REQ-016 SHALL hold out_data and out_last stable while out_valid=1 and out_ready=0.
REQ-017 SHALL assert out_last with the core F_NUM-1 result; after that transfer SHALL go IDLE on the next cycle.
REQ-018 SHALL ignore init, exec and fin while in DRAIN or OUT.
REQ-019 SHALL write w[wsel][wa]=wd on wwrite and bias[wsel]=wd on bwrite only in IDLE; both SHALL be ignored when busy=1.
REQ-020 SHALL give bwrite priority when wwrite and bwrite are asserted together; the weight SHALL not be written.
REQ-021 SHALL ignore wwrite/bwrite when wsel >= F_NUM.
REQ-022 SHALL wrap the accumulator two's-complement at ACCW bits; no overflow flag.

Reset
REQ-023 SHALL, on reset, enter IDLE and set out_valid=0, out_last=0, out_data=0, busy=0, and clear all accumulators and the output index.
REQ-024 SHALL abort any kernel or output stream on reset asserted in any state, with no further out_valid.
REQ-025 SHALL leave weight and bias storage contents undefined after reset; they SHALL not be cleared.

Verification
REQ-026 Bench SHALL cover each directed scenario below (F_NUM=4, DW=16, FRAC=8):
- Basic: core0 w[0..2]=256, bias=128; init, exec x3 with d=512, fin, bias_en=1 -> core0 out_data=1664, else 1536 with bias_en=0.
- Saturation/relu: w=32767, d=32767, 3 execs -> out_data=32767; negate w with relu=1 -> 0; negate w with relu=0 -> -32768.
- Backpressure: out_ready toggles 1/0 each cycle -> exactly 4 transfers, data stable while stalled, out_last only on the 4th, busy drops the cycle after.
- Busy writes: wwrite/bwrite during ACC and OUT -> stored values unchanged; fin with simultaneous exec -> that product included.
- Reset mid-OUT: reset after 2 transfers -> out_valid=0 immediately; new kernel after reset produces 4 correct results.

Source files
------------

// File: rtl/dnn_core_array.sv
// dnn_core_array: F_NUM parallel filter cores sharing one activation stream.
// Each core owns a weight memory and a bias register, accumulates w*d products
// over a kernel through a two-stage MAC, then rounds, biases, saturates and
// optionally rectifies its result. Results are streamed out core by core
// over a valid/ready handshake.
module dnn_core_array #(
    parameter int F_NUM = 16,
    parameter int DW    = 16,
    parameter int FRAC  = 8,
    parameter int AW    = 10,
    parameter int ACCW  = 40
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     init,
    input  logic                     exec,
    input  logic [AW-1:0]            wa,
    input  logic [DW-1:0]            d,
    input  logic                     fin,
    input  logic                     bias_en,
    input  logic                     relu,
    input  logic                     wwrite,
    input  logic                     bwrite,
    input  logic [$clog2(F_NUM)-1:0] wsel,
    input  logic [DW-1:0]            wd,
    output logic                     out_valid,
    output logic [DW-1:0]            out_data,
    output logic                     out_last,
    input  logic                     out_ready,
    output logic                     busy
);

    localparam int IW    = $clog2(F_NUM);
    localparam int DEPTH = 2 ** AW;
    // Post-processing width: two guard bits above the accumulator so that
    // adding the shifted bias and the rounding constant cannot wrap.
    localparam int RW    = ACCW + 2;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACC   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    localparam logic signed [RW-1:0] RND     = RW'(1) <<< (FRAC - 1);
    localparam logic signed [RW-1:0] SAT_MAX = {{(RW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [RW-1:0] SAT_MIN = {{(RW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    // Control state
    logic [1:0]                 state_q, state_d;
    logic                       drain_q;
    logic                       s1_valid_q;
    logic                       bias_en_q;
    logic                       relu_q;
    logic [IW-1:0]              out_idx_q;

    // Datapath state
    logic signed [DW-1:0]       w_mem   [F_NUM][DEPTH];
    logic signed [DW-1:0]       bias_q  [F_NUM];
    logic signed [DW-1:0]       s1_w_q  [F_NUM];
    logic signed [DW-1:0]       s1_d_q;
    logic signed [ACCW-1:0]     acc_q   [F_NUM];
    logic signed [DW-1:0]       res_q   [F_NUM];

    // Per-core combinational results
    logic signed [ACCW-1:0]     prod_ext [F_NUM];
    logic signed [DW-1:0]       res_c    [F_NUM];

    logic in_acc;
    logic clear_acc;
    logic fin_go;
    logic drain_done;
    logic xfer;
    logic wr_ok;

    assign in_acc     = (state_q == S_ACC);
    // init starts a fresh kernel from IDLE and restarts it from ACC.
    assign clear_acc  = init && ((state_q == S_IDLE) || in_acc);
    // A restart in the same cycle as fin wins; the kernel keeps accumulating.
    assign fin_go     = in_acc && fin && !init;
    assign drain_done = (state_q == S_DRAIN) && drain_q;

    assign out_valid  = (state_q == S_OUT);
    assign out_last   = out_valid && (out_idx_q == IW'(F_NUM - 1));
    assign out_data   = out_valid ? res_q[out_idx_q] : '0;
    assign busy       = (state_q != S_IDLE);
    assign xfer       = out_valid && out_ready;
    assign wr_ok      = (state_q == S_IDLE) && (int'(wsel) < F_NUM);

    // Next-state logic for the kernel sequencer.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (init) state_d = S_ACC;
            S_ACC:   if (fin_go) state_d = S_DRAIN;
            S_DRAIN: if (drain_q) state_d = S_OUT;
            S_OUT:   if (xfer && out_last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer state, MAC pipeline valid, fin-time options, accumulators and output index.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: clocked state is updated with non-blocking assignments so every register sees pre-edge values.
        if (reset) begin
            state_q    <= S_IDLE;
            drain_q    <= 1'b0;
            s1_valid_q <= 1'b0;
            bias_en_q  <= 1'b0;
            relu_q     <= 1'b0;
            out_idx_q  <= '0;
            for (int i = 0; i < F_NUM; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            // Two DRAIN cycles: the first lets the last product land in acc.
            drain_q    <= (state_q == S_DRAIN) ? !drain_q : 1'b0;
            s1_valid_q <= in_acc && exec;

            if (fin_go) begin
                bias_en_q <= bias_en;
                relu_q    <= relu;
            end

            for (int i = 0; i < F_NUM; i++) begin
                if (clear_acc) begin
                    acc_q[i] <= '0;
                end else if (s1_valid_q) begin
                    acc_q[i] <= acc_q[i] + prod_ext[i];
                end
            end

            if (state_q != S_OUT) begin
                out_idx_q <= '0;
            end else if (xfer && !out_last) begin
                out_idx_q <= out_idx_q + 1'b1;
            end
        end
    end

    // Weight/bias storage, MAC stage-1 operand registers and the result bank.
    always_ff @(posedge clk) begin
        // NOTE: storage and pure data registers carry no reset; their contents are only consumed once qualified by control state.
        if (in_acc && exec) begin
            s1_d_q <= d;
            for (int i = 0; i < F_NUM; i++) begin
                s1_w_q[i] <= w_mem[i][wa];
            end
        end

        if (drain_done) begin
            for (int i = 0; i < F_NUM; i++) begin
                res_q[i] <= res_c[i];
            end
        end

        if (wr_ok) begin
            if (bwrite) begin
                bias_q[wsel] <= wd;
            end else if (wwrite) begin
                w_mem[wsel][wa] <= wd;
            end
        end
    end

    for (genvar i = 0; i < F_NUM; i++) begin : g_core
        logic signed [2*DW-1:0] prod;
        logic signed [RW-1:0]   bias_term;
        logic signed [RW-1:0]   sum;
        logic signed [RW-1:0]   shr;
        logic signed [DW-1:0]   sat;

        // Operands are sign-extended first so the low 2*DW bits are the exact signed product.
        assign prod        = (2*DW)'(s1_w_q[i]) * (2*DW)'(s1_d_q);
        assign prod_ext[i] = {{(ACCW-2*DW){prod[2*DW-1]}}, prod};
        assign res_c[i]    = sat;

        // Bias, round-half-up, arithmetic shift, saturate, then optional rectify.
        always_comb begin
            bias_term = '0;
            if (bias_en_q) begin
                bias_term = {{(RW-DW){bias_q[i][DW-1]}}, bias_q[i]} <<< FRAC;
            end
            sum = {{2{acc_q[i][ACCW-1]}}, acc_q[i]} + bias_term + RND;
            shr = sum >>> FRAC;
            if (shr > SAT_MAX) begin
                sat = SAT_MAX[DW-1:0];
            end else if (shr < SAT_MIN) begin
                sat = SAT_MIN[DW-1:0];
            end else begin
                sat = shr[DW-1:0];
            end
            if (relu_q && sat[DW-1]) begin
                sat = '0;
            end
        end
    end

endmodule

// File: tb/tb_dnn_core_array.sv
// Scoreboard bench for dnn_core_array (F_NUM=4, DW=16, FRAC=8).
// Stimulus pushes hand-computed expected results; a negedge monitor compares
// every presented output against the queue head and pops on each transfer.
module tb_dnn_core_array;

    localparam int F    = 4;
    localparam int DW   = 16;
    localparam int FRAC = 8;
    localparam int AW   = 10;
    localparam int ACCW = 40;

    typedef struct packed {
        logic signed [DW-1:0] data;
        logic                 last;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          init, exec, fin, bias_en, relu, wwrite, bwrite;
    logic [AW-1:0] wa;
    logic [DW-1:0] d, wd;
    logic [1:0]    wsel;
    logic          out_valid, out_last, busy;
    logic [DW-1:0] out_data;
    logic          out_ready = 1'b1;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   pops    = 0;
    bit   ready_toggle = 1'b0;
    bit   expect_idle  = 1'b0;

    always #5 clk = ~clk;

    dnn_core_array #(.F_NUM(F), .DW(DW), .FRAC(FRAC), .AW(AW), .ACCW(ACCW)) dut (
        .clk(clk), .reset(reset), .init(init), .exec(exec), .wa(wa), .d(d),
        .fin(fin), .bias_en(bias_en), .relu(relu), .wwrite(wwrite),
        .bwrite(bwrite), .wsel(wsel), .wd(wd), .out_valid(out_valid),
        .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .busy(busy)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Sink: always ready, or toggling every cycle for backpressure.
    always @(posedge clk) begin
        #1;
        out_ready = ready_toggle ? ~out_ready : 1'b1;
    end

    // Monitor: compare presented output with the scoreboard head.
    always @(negedge clk) begin
        if (!reset) begin
            if (expect_idle) begin
                check("busy_after_last", busy, 0);
                expect_idle = 1'b0;
            end
            if (out_valid) begin
                check("queue_nonempty", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    check("out_data", $signed(out_data), exp_q[0].data);
                    check("out_last", out_last, exp_q[0].last);
                    if (out_ready) begin
                        if (exp_q[0].last) expect_idle = 1'b1;
                        void'(exp_q.pop_front());
                        pops++;
                    end
                end
            end
        end
    end

    // mode 0: weight, 1: bias, 2: both strobes together (bias must win)
    task automatic wr(input int mode, input int core, input int addr, input int val);
        @(posedge clk); #1;
        wwrite = (mode != 1);
        bwrite = (mode != 0);
        wsel   = core[1:0];
        wa     = addr[AW-1:0];
        wd     = val[DW-1:0];
        @(posedge clk); #1;
        wwrite = 1'b0;
        bwrite = 1'b0;
    endtask

    // Same weight at addresses 0..2 per core; core 3 bias goes in with both strobes.
    task automatic load_cfg(input int w[4], input int b[4]);
        for (int c = 0; c < F; c++)
            for (int a = 0; a < 3; a++)
                wr(0, c, a, w[c]);
        for (int c = 0; c < F - 1; c++)
            wr(1, c, 0, b[c]);
        wr(2, F - 1, 0, b[F-1]);
    endtask

    // init, three execs (the third together with fin), then optionally wait for the stream.
    task automatic kernel(input int dval, input bit be, input bit rl, input int e[4],
                          input bit busy_wr, input bit wait_done);
        int cyc;
        for (int c = 0; c < F; c++)
            exp_q.push_back(exp_t'{data: e[c][DW-1:0], last: (c == F - 1)});
        @(posedge clk); #1;
        init = 1'b1;
        @(posedge clk); #1;
        init = 1'b0;
        for (int k = 0; k < 3; k++) begin
            exec    = 1'b1;
            wa      = AW'(k);
            d       = dval[DW-1:0];
            fin     = (k == 2);
            bias_en = be;
            relu    = rl;
            wwrite  = busy_wr && (k == 0);
            bwrite  = busy_wr && (k == 1);
            wsel    = 2'd0;
            wd      = 16'h1000;
            @(posedge clk); #1;
        end
        exec = 1'b0; fin = 1'b0; bias_en = 1'b0; relu = 1'b0;
        wwrite = 1'b0; bwrite = 1'b0;
        if (wait_done) begin
            cyc = 0;
            while ((busy || exp_q.size() != 0) && cyc < 400) begin
                wwrite = busy_wr && busy && cyc[0];
                bwrite = busy_wr && busy && !cyc[0];
                wsel   = 2'd1;
                wa     = AW'(1);
                wd     = 16'd999;
                @(posedge clk); #1;
                cyc++;
            end
            wwrite = 1'b0;
            bwrite = 1'b0;
            check("stream_done", exp_q.size(), 0);
            check("busy_idle", busy, 0);
        end
    endtask

    initial begin
        int p0;
        int cyc;
        reset = 1'b1;
        init = 0; exec = 0; fin = 0; bias_en = 0; relu = 0;
        wwrite = 0; bwrite = 0; wa = '0; d = '0; wsel = '0; wd = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;

        // Basic: core0 w=1.0 b=0.5, d=2.0 x3 -> 6.5 (1664) with bias, 6.0 (1536) without.
        load_cfg('{256, 128, -256, 0}, '{128, 0, -256, 64});
        kernel(512, 1'b1, 1'b0, '{1664, 768, -1792, 64}, 1'b0, 1'b1);
        kernel(512, 1'b0, 1'b0, '{1536, 768, -1536, 0}, 1'b0, 1'b1);

        // Backpressure: toggling ready, exactly four transfers.
        ready_toggle = 1'b1;
        p0 = pops;
        kernel(512, 1'b1, 1'b0, '{1664, 768, -1792, 64}, 1'b0, 1'b1);
        check("bp_transfers", pops - p0, 4);
        ready_toggle = 1'b0;

        // Writes while busy are dropped: both this kernel and the next see the original storage.
        kernel(512, 1'b1, 1'b0, '{1664, 768, -1792, 64}, 1'b1, 1'b1);
        kernel(512, 1'b1, 1'b0, '{1664, 768, -1792, 64}, 1'b0, 1'b1);

        // Reset after two transfers aborts the stream.
        p0 = pops;
        kernel(512, 1'b1, 1'b0, '{1664, 768, -1792, 64}, 1'b0, 1'b0);
        cyc = 0;
        while (pops < p0 + 2 && cyc < 400) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        reset = 1'b1;
        #1;
        check("mid_rst_pops", pops - p0, 2);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_out_last", out_last, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        load_cfg('{256, 128, -256, 0}, '{128, 0, -256, 64});
        kernel(512, 1'b1, 1'b0, '{1664, 768, -1792, 64}, 1'b0, 1'b1);

        // Saturation and relu.
        load_cfg('{32767, 32767, 1, -1}, '{0, 0, 0, 0});
        kernel(32767, 1'b0, 1'b0, '{32767, 32767, 384, -384}, 1'b0, 1'b1);
        load_cfg('{-32767, -32767, -1, 1}, '{0, 0, 0, 0});
        kernel(32767, 1'b0, 1'b1, '{0, 0, 0, 384}, 1'b0, 1'b1);
        kernel(32767, 1'b0, 1'b0, '{-32768, -32768, -384, 384}, 1'b0, 1'b1);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
